// File: rtl/demux1_2_reg_if.sv
// Producer/consumer bundle for the registered 1-to-2 demux.
// Define DEMUX_CNT_EN to add per-channel handshake counters.
interface demux1_2_reg_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             s;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2;
    logic             out2_valid;
    logic             out2_ready;
`ifdef DEMUX_CNT_EN
    logic [7:0]       out1_cnt;
    logic [7:0]       out2_cnt;
`endif

    // Environment side: producer plus both consumers.
    modport master (
        output in, in_valid, s, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid
`ifdef DEMUX_CNT_EN
        , input out1_cnt, out2_cnt
`endif
    );

    // Demux side.
    modport slave (
        input  in, in_valid, s, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid
`ifdef DEMUX_CNT_EN
        , output out1_cnt, out2_cnt
`endif
    );
endinterface

// File: rtl/demux1_2_reg.sv
// Registered 1-to-2 demux: steers one valid/ready stream into two one-entry channels.
// Optional DEMUX_CNT_EN adds saturating 8-bit handshake counters per channel.
module demux1_2_reg #(
    parameter int unsigned WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1_2_reg_if.slave      bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        state1;
    ch_state_t        state2;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;

    logic free1_c;
    logic free2_c;
    logic accept_c;
    logic load1_c;
    logic load2_c;
    logic drain1_c;
    logic drain2_c;

    // A channel can take a word if empty or if its held word leaves this cycle.
    assign free1_c  = (state1 == EMPTY) || bus.out1_ready;
    assign free2_c  = (state2 == EMPTY) || bus.out2_ready;
    assign drain1_c = (state1 == FULL) && bus.out1_ready;
    assign drain2_c = (state2 == FULL) && bus.out2_ready;

    // Ready follows the currently selected channel; held low during reset.
    assign bus.in_ready = rst_n && (bus.s ? free1_c : free2_c);
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign load1_c      = accept_c && bus.s;
    assign load2_c      = accept_c && !bus.s;

    // Channel 1 holding register; a same-cycle load wins over the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1 <= EMPTY;
            data1  <= '0;
        end else begin
            case (state1)
                EMPTY: begin
                    if (load1_c) begin
                        state1 <= FULL;
                        data1  <= bus.in;
                    end
                end
                FULL: begin
                    if (load1_c) begin
                        data1 <= bus.in;
                    end else if (drain1_c) begin
                        state1 <= EMPTY;
                    end
                end
                default: state1 <= EMPTY;
            endcase
        end
    end

    // Channel 2 holding register, mirror of channel 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state2 <= EMPTY;
            data2  <= '0;
        end else begin
            case (state2)
                EMPTY: begin
                    if (load2_c) begin
                        state2 <= FULL;
                        data2  <= bus.in;
                    end
                end
                FULL: begin
                    if (load2_c) begin
                        data2 <= bus.in;
                    end else if (drain2_c) begin
                        state2 <= EMPTY;
                    end
                end
                default: state2 <= EMPTY;
            endcase
        end
    end

    assign bus.out1       = data1;
    assign bus.out2       = data2;
    assign bus.out1_valid = (state1 == FULL);
    assign bus.out2_valid = (state2 == FULL);

`ifdef DEMUX_CNT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    // Completed output handshakes, saturating rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (drain1_c && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
            if (drain2_c && (cnt2 != '1)) begin
                cnt2 <= cnt2 + CNT_W'(1);
            end
        end
    end

    assign bus.out1_cnt = cnt1;
    assign bus.out2_cnt = cnt2;
`endif
endmodule

// File: tb/tb_demux1_2_reg.sv
// Directed self-checking bench for demux1_2_reg.
module tb_demux1_2_reg;
    localparam int unsigned WIDTH = 2;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    demux1_2_reg_if #(.WIDTH(WIDTH)) bus ();

    demux1_2_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n          = 1'b0;
        bus.in         = '0;
        bus.in_valid   = 1'b0;
        bus.s          = 1'b1;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_in_ready", 8'(bus.in_ready), 8'd0);
        chk("rst_out1_valid", 8'(bus.out1_valid), 8'd0);
        chk("rst_out2_valid", 8'(bus.out2_valid), 8'd0);
        chk("rst_out1", 8'(bus.out1), 8'd0);
        chk("rst_out2", 8'(bus.out2), 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 8'(bus.in_ready), 8'd1);

        // Routing to channel 1
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.in = 2'b10; bus.s = 1'b1; bus.in_valid = 1'b1;
        #1;
        chk("route1_in_ready", 8'(bus.in_ready), 8'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("route1_out1", 8'(bus.out1), 8'h2);
        chk("route1_out1_valid", 8'(bus.out1_valid), 8'd1);
        chk("route1_out2_valid", 8'(bus.out2_valid), 8'd0);

        // Routing to channel 2
        bus.in = 2'b01; bus.s = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("route2_out2", 8'(bus.out2), 8'h1);
        chk("route2_out2_valid", 8'(bus.out2_valid), 8'd1);
        chk("route2_out1_hold", 8'(bus.out1), 8'h2);
        chk("route2_out1_valid", 8'(bus.out1_valid), 8'd1);

        // Drain channel 2 only; its data register holds
        bus.out2_ready = 1'b1;
        tick();
        bus.out2_ready = 1'b0;
        chk("drain2_valid", 8'(bus.out2_valid), 8'd0);
        chk("drain2_hold", 8'(bus.out2), 8'h1);
        chk("drain2_ch1_kept", 8'(bus.out1_valid), 8'd1);

        // Backpressure on channel 1, then reselect channel 2
        bus.in = 2'b11; bus.s = 1'b1; bus.in_valid = 1'b1;
        #1;
        chk("bp_in_ready", 8'(bus.in_ready), 8'd0);
        tick();
        chk("bp_out1_stable", 8'(bus.out1), 8'h2);
        chk("bp_out2_valid", 8'(bus.out2_valid), 8'd0);
        bus.s = 1'b0;
        #1;
        chk("bp_reselect_ready", 8'(bus.in_ready), 8'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out2", 8'(bus.out2), 8'h3);
        chk("bp_out2_valid2", 8'(bus.out2_valid), 8'd1);
        chk("bp_out1_kept", 8'(bus.out1), 8'h2);

        // Empty both channels
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        tick();
        chk("empty_out1_valid", 8'(bus.out1_valid), 8'd0);
        chk("empty_out2_valid", 8'(bus.out2_valid), 8'd0);

        // Full throughput on channel 1
        bus.s = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in = 2'(i);
            #1;
            chk($sformatf("thru_ready_%0d", i), 8'(bus.in_ready), 8'd1);
            tick();
            chk($sformatf("thru_out1_%0d", i), 8'(bus.out1), 8'(i));
            chk($sformatf("thru_valid_%0d", i), 8'(bus.out1_valid), 8'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("thru_done_valid", 8'(bus.out1_valid), 8'd0);

        // Alternating select with channel 2 consumer stalled
        bus.out2_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.s = 1'b1; bus.in = 2'd1;
        tick();
        chk("alt_a_out1", 8'(bus.out1), 8'h1);
        bus.s = 1'b0; bus.in = 2'd2;
        #1;
        chk("alt_b_ready", 8'(bus.in_ready), 8'd1);
        tick();
        chk("alt_b_out2", 8'(bus.out2), 8'h2);
        chk("alt_b_out1_drained", 8'(bus.out1_valid), 8'd0);
        bus.s = 1'b1; bus.in = 2'd3;
        tick();
        chk("alt_c_out1", 8'(bus.out1), 8'h3);
        chk("alt_c_out1_valid", 8'(bus.out1_valid), 8'd1);
        bus.s = 1'b0; bus.in = 2'd0;
        #1;
        chk("alt_d_stall", 8'(bus.in_ready), 8'd0);
        tick();
        chk("alt_d_out2_kept", 8'(bus.out2), 8'h2);
        chk("alt_d_out2_valid", 8'(bus.out2_valid), 8'd1);
        chk("alt_d_out1_drained", 8'(bus.out1_valid), 8'd0);
        bus.out2_ready = 1'b1;
        #1;
        chk("alt_e_ready", 8'(bus.in_ready), 8'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("alt_e_out2", 8'(bus.out2), 8'h0);
        chk("alt_e_out2_valid", 8'(bus.out2_valid), 8'd1);
        tick();
        chk("alt_f_out2_valid", 8'(bus.out2_valid), 8'd0);

        // Asynchronous reset with both channels full
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.s = 1'b1; bus.in = 2'd1;
        tick();
        bus.s = 1'b0; bus.in = 2'd2;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_out1_valid", 8'(bus.out1_valid), 8'd1);
        chk("pre_rst_out2_valid", 8'(bus.out2_valid), 8'd1);
        bus.s = 1'b1;
        bus.out1_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out1", 8'(bus.out1), 8'd0);
        chk("arst_out2", 8'(bus.out2), 8'd0);
        chk("arst_out1_valid", 8'(bus.out1_valid), 8'd0);
        chk("arst_out2_valid", 8'(bus.out2_valid), 8'd0);
        chk("arst_in_ready", 8'(bus.in_ready), 8'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", 8'(bus.in_ready), 8'd1);

`ifdef DEMUX_CNT_EN
        // Saturating handshake counter on channel 1
        chk("cnt1_after_rst", bus.out1_cnt, 8'd0);
        bus.out1_ready = 1'b1;
        bus.s = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in = 2'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("cnt1_sat", bus.out1_cnt, 8'd255);
        chk("cnt2_zero", bus.out2_cnt, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
